pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the five-stage MIPS32-style core. Sits beside the ID/EX boundary. Tracks destination registers of in-flight instructions, stalls decode on read-after-write hazards, flushes younger instructions on a taken branch from execute, and drains the pipeline on HLT. Also keeps saturating stall and flush counters for bring-up.

---
 rtl/mips_pkg.sv | 54 +++++
 rtl/pipe_hazard_ctrl_if.sv | 30 +++
 rtl/ir_regs_decode.sv | 53 +++++
 rtl/pipe_hazard_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, IR field positions,
// hazard-controller state and scoreboard types.
package mips_pkg;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [5:0] OP_LW    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b100001;
  localparam logic [5:0] OP_BEQZ  = 6'b110100;
  localparam logic [5:0] OP_BNEQZ = 6'b110101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // ADD r0,r0,r0: what a bubble looks like in ID/EX
  localparam logic [31:0] NOP_IR = 32'h0000_0000;

  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } hz_state_e;

  typedef struct packed {
    logic       src1_used;
    logic [4:0] src1;
    logic       src2_used;
    logic [4:0] src2;
    logic       dst_used;
    logic [4:0] dst;
  } ir_regs_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
  } sb_ent_t;

  function automatic logic hits(
    input sb_ent_t    e,
    input logic       used,
    input logic [4:0] r
  );
    return used && (r != 5'd0) &&
           e.valid && (e.dst == r);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side control bundle between the hazard
// controller and the IF/ID/EX datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_ir;
  logic             id_valid;
  logic             ex_sel;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ir, id_valid, ex_sel,
    input  pc_we, if_id_we, if_id_flush,
    input  id_ex_bubble, halted,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ir, id_valid, ex_sel,
    output pc_we, if_id_we, if_id_flush,
    output id_ex_bubble, halted,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/ir_regs_decode.sv
// Register-usage decode of the instruction sitting in IF/ID.
// Pure combinational; r0 filtering is left to the consumer.
module ir_regs_decode
  import mips_pkg::*;
(
  input  logic [31:0] ir_i,
  output ir_regs_t    regs_o
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op = ir_i[OP_HI:OP_LO];
  assign rs = ir_i[RS_HI:RS_LO];
  assign rt = ir_i[RT_HI:RT_LO];
  assign rd = ir_i[RD_HI:RD_LO];

  always_comb begin
    regs_o = '0;
    unique case (1'b1)
      (!op[5] && !op[4]): begin
        regs_o.src1_used = 1'b1;
        regs_o.src1      = rs;
        regs_o.src2_used = 1'b1;
        regs_o.src2      = rt;
        regs_o.dst_used  = 1'b1;
        regs_o.dst       = rd;
      end
      (!op[5] && op[4]),
      (op == OP_LW): begin
        regs_o.src1_used = 1'b1;
        regs_o.src1      = rs;
        regs_o.dst_used  = 1'b1;
        regs_o.dst       = rt;
      end
      (op == OP_SW): begin
        regs_o.src1_used = 1'b1;
        regs_o.src1      = rs;
        regs_o.src2_used = 1'b1;
        regs_o.src2      = rt;
      end
      (op == OP_BEQZ),
      (op == OP_BNEQZ): begin
        regs_o.src1_used = 1'b1;
        regs_o.src1      = rs;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX sequencing: RAW stall, branch flush, HLT drain,
// plus saturating stall/flush counters.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  ir_regs_t   regs;
  sb_ent_t    ex_q, ex_d, mem_q;
  hz_state_e  state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       halted_q;
  logic       raw;
  logic       is_hlt;
  logic       issue;
  logic       stall_inc;
  logic       flush_inc;
  logic       pc_we;
  logic       if_id_we;
  logic       if_id_flush;
  logic       id_ex_bubble;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  ir_regs_decode u_dec (
    .ir_i   (bus.id_ir),
    .regs_o (regs)
  );

  assign raw = bus.id_valid && (
    hits(ex_q,  regs.src1_used, regs.src1) ||
    hits(mem_q, regs.src1_used, regs.src1) ||
    hits(ex_q,  regs.src2_used, regs.src2) ||
    hits(mem_q, regs.src2_used, regs.src2));

  assign is_hlt = bus.id_valid &&
    (bus.id_ir[OP_HI:OP_LO] == OP_HLT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_RUN: begin
        if (!bus.ex_sel && !raw && is_hlt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_CYCLES;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q - 2'd1;
        if (drain_q == 2'd1) state_d = ST_HALTED;
      end
      ST_HALTED: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    issue        = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (state_q == ST_RUN) begin
      priority case (1'b1)
        bus.ex_sel: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          flush_inc    = 1'b1;
        end
        raw: begin
          pc_we        = 1'b0;
          if_id_we     = 1'b0;
          id_ex_bubble = 1'b1;
          stall_inc    = 1'b1;
        end
        is_hlt: begin
          pc_we    = 1'b0;
          if_id_we = 1'b0;
          issue    = 1'b1;
        end
        default: issue = bus.id_valid;
      endcase
    end else begin
      // draining or halted: freeze front end, feed bubbles
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_comb begin
    ex_d.valid = issue && regs.dst_used &&
                 (regs.dst != 5'd0);
    ex_d.dst   = regs.dst;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else begin
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.pc_we        = pc_we;
  assign bus.if_id_we     = if_id_we;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_bubble = id_ex_bubble;
  assign bus.halted       = halted_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule
